// File: rtl/simd_vector_alu_pipe_if.sv
// Handshake and operand/result bus for the SIMD vector ALU pipeline.
interface simd_vector_alu_pipe_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [15:0]               instruction;
    logic [LANES-1:0]          lane_en;
    logic [LANES*LANE_W-1:0]   src_a;
    logic [LANES*LANE_W-1:0]   src_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   result;
    logic [LANES-1:0]          ovf;

    // Issue stage / writeback consumer side
    modport master (
        output in_valid, instruction, lane_en, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    // ALU side
    modport slave (
        input  in_valid, instruction, lane_en, src_a, src_b, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/simd_vector_alu_pipe.sv
// Two-stage LANES x LANE_W SIMD integer ALU with valid/ready backpressure,
// optional unsigned saturation, per-lane overflow and per-lane MAC accumulator.
module simd_vector_alu_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
) (
    input logic                    clk,
    input logic                    reset_n,
    simd_vector_alu_pipe_if.slave  bus
);
    localparam int unsigned DW = LANES * LANE_W;
    localparam int unsigned PW = 2 * LANE_W;
    localparam int unsigned AW = 2 * LANE_W + 1;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_MAC   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_XOR   = 3'd6;
    localparam logic [2:0] OP_RDCLR = 3'd7;

    localparam logic [LANE_W-1:0] LANE_MAX = {LANE_W{1'b1}};

    // Stage 1 holding registers
    logic                s1_valid;
    logic [2:0]          s1_op;
    logic                s1_sat;
    logic [LANES-1:0]    s1_en;
    logic [DW-1:0]       s1_a;
    logic [DW-1:0]       s1_b;
    logic [PW-1:0]       s1_prod [LANES];

    // Stage 2 / output registers and accumulators
    logic                out_valid_q;
    logic [DW-1:0]       result_q;
    logic [LANES-1:0]    ovf_q;
    logic [LANE_W-1:0]   acc [LANES];

    logic                s2_load;
    logic                s1_adv;
    logic                in_ready_c;
    logic                in_fire;
    logic [PW-1:0]       prod_c [LANES];
    logic [DW-1:0]       res_c;
    logic [LANES-1:0]    ovf_c;
    logic [LANE_W-1:0]   acc_nxt [LANES];
    logic [AW-1:0]       lane_out;
    logic                unused_instr;

    // Per-lane operation: returns {acc_next, ovf, result}
    function automatic logic [AW-1:0] lane_op(
        input logic [2:0]        op,
        input logic              sat,
        input logic              en,
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b,
        input logic [PW-1:0]     prod,
        input logic [LANE_W-1:0] acc_q
    );
        logic [LANE_W:0]   sum;
        logic [LANE_W:0]   diff;
        logic [LANE_W:0]   mac;
        logic [LANE_W-1:0] res;
        logic [LANE_W-1:0] acc_n;
        logic              flag;
        logic              hi_nz;
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        mac   = {1'b0, acc_q} + {1'b0, prod[LANE_W-1:0]};
        hi_nz = |prod[PW-1:LANE_W];
        res   = '0;
        flag  = 1'b0;
        acc_n = acc_q;
        case (op)
            OP_ADD: begin
                flag = sum[LANE_W];
                res  = (sat && flag) ? LANE_MAX : sum[LANE_W-1:0];
            end
            OP_MUL: begin
                flag = hi_nz;
                res  = (sat && flag) ? LANE_MAX : prod[LANE_W-1:0];
            end
            OP_SUB: begin
                flag = diff[LANE_W];
                res  = (sat && flag) ? '0 : diff[LANE_W-1:0];
            end
            OP_MAC: begin
                flag  = hi_nz | mac[LANE_W];
                res   = (sat && flag) ? LANE_MAX : mac[LANE_W-1:0];
                acc_n = res;
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_RDCLR: begin
                res   = acc_q;
                acc_n = '0;
            end
            default: res = '0;
        endcase
        if (!en) begin
            res   = '0;
            flag  = 1'b0;
            acc_n = acc_q;
        end
        return {acc_n, flag, res};
    endfunction

    // Reserved instruction bits carry no meaning here
    assign unused_instr = ^bus.instruction[11:0];

    // Pipeline handshake
    always_comb begin
        s2_load    = !out_valid_q || bus.out_ready;
        s1_adv     = s1_valid && s2_load;
        in_ready_c = !s1_valid || s1_adv;
        in_fire    = bus.in_valid && in_ready_c;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;

    // Full-width lane products from the incoming operands
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_c[i] = PW'(bus.src_a[i*LANE_W +: LANE_W]) * PW'(bus.src_b[i*LANE_W +: LANE_W]);
        end
    end

    // Stage 1 capture on input transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_sat   <= 1'b0;
            s1_en    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= bus.instruction[15:13];
            s1_sat   <= bus.instruction[12];
            s1_en    <= bus.lane_en;
            s1_a     <= bus.src_a;
            s1_b     <= bus.src_b;
            for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= prod_c[i];
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Lane results, flags and next accumulator values from stage 1
    always_comb begin
        res_c    = '0;
        ovf_c    = '0;
        lane_out = '0;
        acc_nxt  = acc;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_out = lane_op(s1_op, s1_sat, s1_en[i], s1_a[i*LANE_W +: LANE_W],
                               s1_b[i*LANE_W +: LANE_W], s1_prod[i], acc[i]);
            res_c[i*LANE_W +: LANE_W] = lane_out[LANE_W-1:0];
            ovf_c[i]                  = lane_out[LANE_W];
            acc_nxt[i]                = lane_out[AW-1:LANE_W+1];
        end
    end

    // Stage 2 / output register and accumulator update on s1->s2 transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= '0;
            for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            result_q    <= res_c;
            ovf_q       <= ovf_c;
            acc         <= acc_nxt;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_simd_vector_alu_pipe.sv
// Self-checking bench for simd_vector_alu_pipe: directed vectors with literal
// expectations plus a per-cycle compare against an arithmetic lane model.
module tb_simd_vector_alu_pipe;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam longint unsigned M  = 64'h1_0000_0000;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_MAC   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_XOR   = 3'd6;
    localparam logic [2:0] OP_RDCLR = 3'd7;

    typedef struct {
        logic [127:0] res;
        logic [3:0]   ovf;
    } exp_t;

    logic clk;
    logic reset_n;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_accept = 0;
    exp_t exp_q[$];
    longint unsigned macc [4];

    simd_vector_alu_pipe_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    simd_vector_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [127:0] v(input logic [31:0] d3, input logic [31:0] d2,
                                       input logic [31:0] d1, input logic [31:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Lane model: plain unsigned arithmetic on 64-bit values
    function automatic void model_push(input logic [15:0] instr, input logic [3:0] en,
                                       input logic [127:0] a, input logic [127:0] b);
        exp_t e;
        logic [2:0] op;
        logic s;
        longint unsigned A, B, P, T, R;
        logic o;
        op = instr[15:13];
        s  = instr[12];
        e.res = '0;
        e.ovf = '0;
        for (int i = 0; i < 4; i++) begin
            A = 64'(a[i*32 +: 32]);
            B = 64'(b[i*32 +: 32]);
            P = A * B;
            R = 0;
            o = 1'b0;
            if (en[i]) begin
                case (op)
                    OP_ADD: begin T = A + B; o = (T >= M); R = o ? (s ? M - 1 : T - M) : T; end
                    OP_MUL: begin o = (P >= M); R = o ? (s ? M - 1 : P % M) : P; end
                    OP_SUB: begin o = (A < B); R = o ? (s ? 0 : A + M - B) : A - B; end
                    OP_MAC: begin
                        T = macc[i] + P;
                        o = (T >= M);
                        R = (o && s) ? M - 1 : T % M;
                        macc[i] = R;
                    end
                    OP_AND: R = A & B;
                    OP_OR:  R = A | B;
                    OP_XOR: R = A ^ B;
                    default: begin R = macc[i]; macc[i] = 0; end
                endcase
            end
            e.res[i*32 +: 32] = R[31:0];
            e.ovf[i] = o;
        end
        exp_q.push_back(e);
    endfunction

    // Per-cycle compare of the output stream against the model queue
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) macc[i] = 0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1'b1, 1'b0);
                end else begin
                    chk("stream_result", bus.result, exp_q[0].res);
                    chk("stream_ovf", bus.ovf, exp_q[0].ovf);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_push(bus.instruction, bus.lane_en, bus.src_a, bus.src_b);
                n_accept++;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic sat, input logic [3:0] en,
                        input logic [127:0] a, input logic [127:0] b);
        int unsigned n;
        n = 0;
        bus.in_valid    = 1'b1;
        bus.instruction = {op, sat, 12'hA5C};
        bus.lane_en     = en;
        bus.src_a       = a;
        bus.src_b       = b;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single unstalled instruction with latency and literal result check
    task automatic do_op(input string name, input logic [2:0] op, input logic sat, input logic [3:0] en,
                         input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] er, input logic [3:0] eo);
        send(op, sat, en, a, b);
        chk({name, "_lat1"}, bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({name, "_lat2"}, bus.out_valid, 1'b1);
        chk({name, "_res"}, bus.result, er);
        chk({name, "_ovf"}, bus.ovf, eo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] la, lb, ones, mb;
        int unsigned acc0;
        clk             = 1'b0;
        reset_n         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.instruction = '0;
        bus.lane_en     = '0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        chk("reset_result", bus.result, '0);
        chk("reset_ovf", bus.ovf, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("add", OP_ADD, 1'b0, 4'hF, v(4, 3, 2, 1), v(40, 30, 20, 10), v(44, 33, 22, 11), 4'b0000);
        do_op("add_wrap", OP_ADD, 1'b0, 4'hF, v(0, 0, 0, 32'hFFFF_FFFF), v(0, 0, 0, 2), v(0, 0, 0, 1), 4'b0001);
        do_op("add_sat", OP_ADD, 1'b1, 4'hF, v(0, 0, 0, 32'hFFFF_FFFF), v(0, 0, 0, 2), v(0, 0, 0, 32'hFFFF_FFFF), 4'b0001);
        do_op("mul", OP_MUL, 1'b0, 4'hF, v(4, 3, 2, 1), v(5, 6, 7, 8), v(20, 18, 14, 8), 4'b0000);
        do_op("mul_sat", OP_MUL, 1'b1, 4'hF, v(4, 3, 2, 32'h1_0000), v(5, 6, 7, 32'h1_0000), v(20, 18, 14, 32'hFFFF_FFFF), 4'b0001);
        do_op("mul_wrap", OP_MUL, 1'b0, 4'hF, v(4, 3, 2, 32'h1_0000), v(5, 6, 7, 32'h1_0000), v(20, 18, 14, 0), 4'b0001);
        do_op("sub_sat", OP_SUB, 1'b1, 4'hF, v(10, 10, 10, 5), v(1, 2, 3, 9), v(9, 8, 7, 0), 4'b0001);
        do_op("sub_wrap", OP_SUB, 1'b0, 4'hF, v(10, 10, 10, 5), v(1, 2, 3, 9), v(9, 8, 7, 32'hFFFF_FFFC), 4'b0001);

        la = v(32'hFF00_FF00, 32'h0000_FFFF, 32'h1234_5678, 32'hAAAA_AAAA);
        lb = v(32'h0F0F_0F0F, 32'hFFFF_0000, 32'h0000_FFFF, 32'h5555_5555);
        do_op("and", OP_AND, 1'b1, 4'hF, la, lb, v(32'h0F00_0F00, 0, 32'h0000_5678, 0), 4'b0000);
        do_op("or", OP_OR, 1'b1, 4'hF, la, lb, v(32'hFF0F_FF0F, 32'hFFFF_FFFF, 32'h1234_FFFF, 32'hFFFF_FFFF), 4'b0000);
        do_op("xor", OP_XOR, 1'b1, 4'hF, la, lb, v(32'hF00F_F00F, 32'hFFFF_FFFF, 32'h1234_A987, 32'hFFFF_FFFF), 4'b0000);
        do_op("add_en0101", OP_ADD, 1'b0, 4'b0101, v(4, 3, 2, 1), v(40, 30, 20, 10), v(0, 33, 0, 11), 4'b0000);

        ones = v(1, 1, 1, 1);
        mb   = v(5, 4, 3, 2);
        do_op("rdclr0", OP_RDCLR, 1'b0, 4'hF, ones, mb, v(0, 0, 0, 0), 4'b0000);
        do_op("mac1", OP_MAC, 1'b0, 4'hF, ones, mb, v(5, 4, 3, 2), 4'b0000);
        do_op("mac2", OP_MAC, 1'b0, 4'hF, ones, mb, v(10, 8, 6, 4), 4'b0000);
        do_op("rdclr1", OP_RDCLR, 1'b1, 4'hF, ones, mb, v(10, 8, 6, 4), 4'b0000);
        do_op("mac_en0001", OP_MAC, 1'b0, 4'b0001, ones, mb, v(0, 0, 0, 2), 4'b0000);
        do_op("rdclr2", OP_RDCLR, 1'b0, 4'hF, ones, mb, v(0, 0, 0, 2), 4'b0000);
        do_op("mac_sat", OP_MAC, 1'b1, 4'hF, v(0, 0, 0, 32'hFFFF_FFFF), v(0, 0, 0, 2), v(0, 0, 0, 32'hFFFF_FFFF), 4'b0001);
        do_op("mac_carry", OP_MAC, 1'b0, 4'hF, v(0, 0, 0, 1), v(0, 0, 0, 1), v(0, 0, 0, 0), 4'b0001);
        do_op("rdclr3", OP_RDCLR, 1'b0, 4'hF, ones, mb, v(0, 0, 0, 0), 4'b0000);

        // Backpressure: four ADDs offered back-to-back while the consumer stalls
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        acc0 = n_accept;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(OP_ADD, 1'b0, 4'hF, {4{32'(i * 100 + 1)}}, {4{32'(i + 7)}});
                end
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                chk("bp_in_ready_low", bus.in_ready, 1'b0);
                chk("bp_accepts", 128'(n_accept - acc0), 128'd2);
                chk("bp_out_valid_held", bus.out_valid, 1'b1);
                chk("bp_result_held", bus.result, {4{32'd8}});
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_drain_valid", bus.out_valid, 1'b1);
                end
                @(negedge clk);
                chk("bp_drain_done", bus.out_valid, 1'b0);
            end
        join
        chk("bp_total_accepts", 128'(n_accept - acc0), 128'd4);

        // Reset with both stages full and the output stalled
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(OP_MAC, 1'b0, 4'hF, ones, v(7, 7, 7, 7));
        send(OP_ADD, 1'b0, 4'hF, ones, ones);
        @(negedge clk);
        chk("rst_pre_in_ready", bus.in_ready, 1'b0);
        chk("rst_pre_out_valid", bus.out_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, '0);
        chk("rst_ovf", bus.ovf, '0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_idle", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        do_op("post_rst_rdclr", OP_RDCLR, 1'b0, 4'hF, ones, mb, v(0, 0, 0, 0), 4'b0000);

        repeat (3) @(posedge clk);
        #1;
        chk("model_drained", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
